// File: rtl/bit_serial_adder.sv
// Bit-serial W-bit adder: one full-adder step per clock, LSB first.
// A sum takes W clocks in SHIFT, then a one-cycle DONE pulse. After that the FSM returns to IDLE.
module bit_serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_reg;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   res_reg;
  logic           carry_reg;
  logic [CW-1:0]  cnt_reg;

  logic           sum_bit;
  logic           carry_next;
  logic [W-1:0]   res_next;
  logic           last_step;

  bit_serial_adder_fa u_fa (
    .x   (a_reg[0]),
    .y   (b_reg[0]),
    .ci  (carry_reg),
    .sum (sum_bit),
    .co  (carry_next)
  );

  // Sum bits enter at the MSB. After W steps, operand bit 0 has moved down to result bit 0.
  assign res_next  = {sum_bit, res_reg[W-1:1]};
  assign last_step = (cnt_reg == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s         <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            res_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= res_next;
          carry_reg <= carry_next;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_step) begin
            s         <= res_next;
            cout      <= carry_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// Single-bit full adder used for the serial step.
module bit_serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);

endmodule
